// File: rtl/spine_router.sv
// spine_router: spine-side 4x4 switch of a group. Each leaf link feeds a
// small FIFO; each output has a round-robin arbiter and a single-entry
// output register. Flits addressed to another group are dropped at the
// FIFO head and counted.
module spine_router #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  GROUP_ID   = 4'b0100,
  parameter int unsigned SPINE_ID   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_enable,
  input  logic [4*DWIDTH-1:0] leaf_in_data,
  input  logic [4*6-1:0]      leaf_in_dest_addr,
  input  logic [3:0]          leaf_in_valid,
  output logic [3:0]          leaf_in_ready,
  output logic [4*DWIDTH-1:0] leaf_out_data,
  output logic [4*6-1:0]      leaf_out_dest_addr,
  output logic [3:0]          leaf_out_valid,
  input  logic [3:0]          leaf_out_ready,
  output logic [4*2-1:0]      grant_src,
  output logic [7:0]          drop_count,
  output logic                busy
);

  localparam int unsigned NPORT  = 4;
  localparam int unsigned AWIDTH = 6;
  localparam int unsigned EWIDTH = DWIDTH + AWIDTH;
  localparam int unsigned PWIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned CWIDTH = PWIDTH + 1;

  // SPINE_ID is informational only; it does not affect routing.
  logic spine_id_unused;
  assign spine_id_unused = |32'(SPINE_ID);

  // FIFO state; each entry is {dest_addr, data}
  logic [EWIDTH-1:0] fifo_mem [NPORT][FIFO_DEPTH];
  logic [PWIDTH-1:0] rd_ptr_q [NPORT];
  logic [PWIDTH-1:0] wr_ptr_q [NPORT];
  logic [CWIDTH-1:0] count_q  [NPORT];
  logic [1:0]        rr_ptr_q [NPORT];

  // next-state values
  logic [PWIDTH-1:0]   rd_ptr_n [NPORT];
  logic [PWIDTH-1:0]   wr_ptr_n [NPORT];
  logic [CWIDTH-1:0]   count_n  [NPORT];
  logic [1:0]          rr_ptr_n [NPORT];
  logic [3:0]          in_ready_n;
  logic [4*DWIDTH-1:0] out_data_n;
  logic [4*6-1:0]      out_dest_n;
  logic [3:0]          out_valid_n;
  logic [4*2-1:0]      grant_src_n;
  logic [7:0]          drop_count_n;
  logic [8:0]          drop_sum_c;
  logic                busy_n;

  // head classification and arbitration signals
  logic [EWIDTH-1:0] head_entry_c [NPORT];
  logic [AWIDTH-1:0] head_dest_c  [NPORT];
  logic [3:0]        head_valid_c;
  logic [3:0]        drop_c;
  logic [3:0]        push_c;
  logic [3:0]        pop_c;
  logic [3:0]        out_free_c;
  logic [3:0]        gnt_valid_c;
  logic [1:0]        gnt_idx_c [NPORT];
  logic [1:0]        cand_c;

  // Classify each FIFO head: absent, wrong group (drop), or routable.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      head_entry_c[i] = fifo_mem[i][rd_ptr_q[i]];
      head_dest_c[i]  = head_entry_c[i][EWIDTH-1 -: AWIDTH];
      head_valid_c[i] = (count_q[i] != '0);
      drop_c[i]       = head_valid_c[i] && (head_dest_c[i][5:2] != GROUP_ID);
      push_c[i]       = leaf_in_valid[i] && leaf_in_ready[i];
    end
  end

  // Per-output round-robin arbiter, searching from rr_ptr upward.
  always_comb begin
    cand_c = '0;
    for (int o = 0; o < NPORT; o++) begin
      gnt_valid_c[o] = 1'b0;
      gnt_idx_c[o]   = '0;
      out_free_c[o]  = !leaf_out_valid[o] || leaf_out_ready[o];
      for (int k = 0; k < NPORT; k++) begin
        cand_c = rr_ptr_q[o] + 2'(k);
        if (!gnt_valid_c[o] && arb_enable && out_free_c[o] &&
            head_valid_c[cand_c] && !drop_c[cand_c] &&
            (head_dest_c[cand_c][1:0] == 2'(o))) begin
          gnt_valid_c[o] = 1'b1;
          gnt_idx_c[o]   = cand_c;
        end
      end
    end
  end

  // An input pops when its head is dropped or granted by its one target output.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      pop_c[i] = drop_c[i];
      for (int o = 0; o < NPORT; o++) begin
        if (gnt_valid_c[o] && (gnt_idx_c[o] == 2'(i))) begin
          pop_c[i] = 1'b1;
        end
      end
    end
  end

  // Next-state for FIFO pointers/occupancy, output registers and counters.
  always_comb begin
    out_data_n   = leaf_out_data;
    out_dest_n   = leaf_out_dest_addr;
    grant_src_n  = grant_src;
    drop_sum_c   = {1'b0, drop_count};
    busy_n       = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      count_n[i]    = count_q[i] + CWIDTH'(push_c[i]) - CWIDTH'(pop_c[i]);
      wr_ptr_n[i]   = push_c[i] ? wr_ptr_q[i] + PWIDTH'(1) : wr_ptr_q[i];
      rd_ptr_n[i]   = pop_c[i]  ? rd_ptr_q[i] + PWIDTH'(1) : rd_ptr_q[i];
      in_ready_n[i] = (count_n[i] != CWIDTH'(FIFO_DEPTH));
      drop_sum_c    = drop_sum_c + 9'(drop_c[i]);
      if (count_n[i] != '0) begin
        busy_n = 1'b1;
      end
    end
    for (int o = 0; o < NPORT; o++) begin
      rr_ptr_n[o]    = rr_ptr_q[o];
      out_valid_n[o] = leaf_out_valid[o] && !leaf_out_ready[o];
      if (gnt_valid_c[o]) begin
        out_valid_n[o]                     = 1'b1;
        out_data_n[o*DWIDTH +: DWIDTH]     = head_entry_c[gnt_idx_c[o]][DWIDTH-1:0];
        out_dest_n[o*AWIDTH +: AWIDTH]     = head_dest_c[gnt_idx_c[o]];
        grant_src_n[o*2 +: 2]              = gnt_idx_c[o];
        rr_ptr_n[o]                        = gnt_idx_c[o] + 2'd1;
      end
      if (out_valid_n[o]) begin
        busy_n = 1'b1;
      end
    end
    drop_count_n = (drop_sum_c > 9'd255) ? 8'hFF : drop_sum_c[7:0];
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NPORT; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        rr_ptr_q[i] <= '0;
      end
      leaf_in_ready      <= '0;
      leaf_out_data      <= '0;
      leaf_out_dest_addr <= '0;
      leaf_out_valid     <= '0;
      grant_src          <= '0;
      drop_count         <= '0;
      busy               <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        rd_ptr_q[i] <= rd_ptr_n[i];
        wr_ptr_q[i] <= wr_ptr_n[i];
        count_q[i]  <= count_n[i];
        rr_ptr_q[i] <= rr_ptr_n[i];
      end
      leaf_in_ready      <= in_ready_n;
      leaf_out_data      <= out_data_n;
      leaf_out_dest_addr <= out_dest_n;
      leaf_out_valid     <= out_valid_n;
      grant_src          <= grant_src_n;
      drop_count         <= drop_count_n;
      busy               <= busy_n;
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (push_c[i]) begin
        fifo_mem[i][wr_ptr_q[i]] <= {leaf_in_dest_addr[i*AWIDTH +: AWIDTH],
                                     leaf_in_data[i*DWIDTH +: DWIDTH]};
      end
    end
  end

endmodule
